// File: rtl/controlpack.sv
// Shared ALU types: operation codes, flag bundle, multi-cycle controller states
// and small opcode classification helpers.
package controlpack;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_MULH = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_MOD  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic overflow;
    logic negative;
    logic carry;
    logic zero;
  } alu_flag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_mc_state_e;

  function automatic logic is_divide(alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

  function automatic logic is_multicycle(alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_MULH) || is_divide(op);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU: add/sub, bitwise logic and 1-bit shifts,
// with overflow/negative/carry/zero flags. Unknown ops yield zero.
module alu
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  alu_op_e                   op,
  input  logic [DATA_BUS_WIDTH-1:0] register1,
  input  logic [DATA_BUS_WIDTH-1:0] register2,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output alu_flag_t                 flag
);

  localparam int W = DATA_BUS_WIDTH;

  logic [W:0] wide;
  logic       carry;
  logic       overflow;

  always_comb begin
    wide     = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        wide     = {1'b0, register1} + {1'b0, register2};
        result   = wide[W-1:0];
        carry    = wide[W];
        overflow = (register1[W-1] == register2[W-1]) && (result[W-1] != register1[W-1]);
      end
      ALU_SUB: begin
        // carry reports a borrow (register1 < register2 unsigned)
        wide     = {1'b0, register1} - {1'b0, register2};
        result   = wide[W-1:0];
        carry    = wide[W];
        overflow = (register1[W-1] != register2[W-1]) && (result[W-1] != register1[W-1]);
      end
      ALU_AND: result = register1 & register2;
      ALU_OR:  result = register1 | register2;
      ALU_XOR: result = register1 ^ register2;
      ALU_NOT: result = ~register1;
      ALU_SHL: begin
        result = {register1[W-2:0], 1'b0};
        carry  = register1[W-1];
      end
      ALU_SHR: begin
        result = {1'b0, register1[W-1:1]};
        carry  = register1[0];
      end
      default: result = '0;
    endcase
    flag          = '0;
    flag.overflow = overflow;
    flag.negative = result[W-1];
    flag.carry    = carry;
    flag.zero     = (result == '0);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: legacy ops through the combinational alu in one cycle,
// unsigned shift-add multiply and restoring divide over W cycles.
module alu_mc
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  alu_op_e                   op,
  input  logic [DATA_BUS_WIDTH-1:0] register1,
  input  logic [DATA_BUS_WIDTH-1:0] register2,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output alu_flag_t                 flag,
  output logic                      dz
);

  localparam int W  = DATA_BUS_WIDTH;
  localparam int CW = $clog2(W + 1);

  alu_mc_state_e state_reg, state_next;

  alu_op_e       op_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [CW-1:0] cnt_reg;
  logic [2*W-1:0] acc_reg;
  logic [W-1:0]  result_reg;
  alu_flag_t     flag_reg;
  logic          dz_reg;

  logic          accept;
  logic          last;
  logic          div_op;
  logic [W:0]    rem_sh;
  logic [W:0]    add_x;
  logic [W:0]    add_y;
  logic [W:0]    add_sum;
  logic          q_bit;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]  mc_result;
  alu_flag_t     mc_flag;
  logic [W-1:0]  alu_result;
  alu_flag_t     alu_flag;

  alu #(
    .DATA_BUS_WIDTH(W)
  ) u_alu (
    .op       (op_reg),
    .register1(a_reg),
    .register2(b_reg),
    .result   (alu_result),
    .flag     (alu_flag)
  );

  assign accept = start & ready;
  assign last   = (state_reg == RUN) && (!is_multicycle(op_reg) || (cnt_reg == CW'(1)));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_reg != RUN);
    busy  = (state_reg == RUN);
    done  = (state_reg == DONE);
  end

  // One W+1-bit adder/subtractor serves both iterations: multiply adds the
  // multiplicand to the upper half, divide subtracts the divisor from the
  // shifted partial remainder.
  always_comb begin
    div_op  = is_divide(op_reg);
    rem_sh  = acc_reg[2*W-1:W-1];
    add_x   = div_op ? rem_sh : {1'b0, acc_reg[2*W-1:W]};
    add_y   = div_op ? {1'b0, b_reg} : {1'b0, a_reg};
    add_sum = add_x + (add_y ^ {(W+1){div_op}}) + {{W{1'b0}}, div_op};
    q_bit   = ~add_sum[W];
    if (div_op)
      acc_next = {(q_bit ? add_sum[W-1:0] : rem_sh[W-1:0]), acc_reg[W-2:0], q_bit};
    else if (acc_reg[0])
      acc_next = {add_sum, acc_reg[W-1:1]};
    else
      acc_next = {1'b0, acc_reg[2*W-1:W], acc_reg[W-1:1]};
  end

  always_comb begin
    mc_flag = '0;
    case (op_reg)
      ALU_MUL: begin
        mc_result     = acc_next[W-1:0];
        mc_flag.carry = |acc_next[2*W-1:W];
      end
      ALU_MULH: mc_result = acc_next[2*W-1:W];
      ALU_MOD:  mc_result = acc_next[2*W-1:W];
      default:  mc_result = acc_next[W-1:0];
    endcase
    mc_flag.zero = (mc_result == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= ALU_ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      flag_reg   <= '0;
      dz_reg     <= 1'b0;
    end else if (accept) begin
      op_reg  <= op;
      a_reg   <= register1;
      b_reg   <= register2;
      cnt_reg <= CW'(W);
      acc_reg <= {{W{1'b0}}, (is_divide(op) ? register1 : register2)};
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_reg - CW'(1);
      acc_reg <= acc_next;
      if (last) begin
        result_reg <= is_multicycle(op_reg) ? mc_result : alu_result;
        flag_reg   <= is_multicycle(op_reg) ? mc_flag : alu_flag;
        dz_reg     <= div_op && (b_reg == '0);
      end
    end
  end

  assign result = result_reg;
  assign flag   = flag_reg;
  assign dz     = dz_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (W=8): table of vectors plus hand sequences,
// with a done-driven scoreboard checking result, flags, dz and latency.
module tb_alu_mc;
  import controlpack::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  alu_op_e    op = ALU_ADD;
  logic [7:0] register1 = '0;
  logic [7:0] register2 = '0;
  logic       ready, busy, done, dz;
  logic [7:0] result;
  alu_flag_t  flag;

  alu_mc #(.DATA_BUS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .register1(register1), .register2(register2),
    .ready(ready), .busy(busy), .done(done),
    .result(result), .flag(flag), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;   // {overflow, negative, carry, zero}
    logic       dz;
    int         lat;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] flg;
    logic       dz;
    int         lat;
    int         issue_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model built from plain integer arithmetic.
  function automatic exp_t model(alu_op_e o, logic [7:0] a, logic [7:0] b);
    exp_t m;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r = 0;
    int s = 0;
    logic c = 1'b0;
    logic ov = 1'b0;
    logic neg_ok = 1'b1;
    m.lat = 1;
    m.dz = 1'b0;
    m.name = o.name();
    case (o)
      ALU_ADD: begin r = ua + ub; c = (r > 255); s = sa + sb; ov = (s > 127) || (s < -128); end
      ALU_SUB: begin r = ua - ub; c = (ua < ub); s = sa - sb; ov = (s > 127) || (s < -128); end
      ALU_AND: r = ua & ub;
      ALU_OR:  r = ua | ub;
      ALU_XOR: r = ua ^ ub;
      ALU_NOT: r = ~ua;
      ALU_SHL: begin r = ua * 2; c = a[7]; end
      ALU_SHR: begin r = ua / 2; c = a[0]; end
      ALU_MUL: begin r = ua * ub; c = (r > 255); m.lat = 8; neg_ok = 1'b0; end
      ALU_MULH: begin r = (ua * ub) / 256; m.lat = 8; neg_ok = 1'b0; end
      ALU_DIV: begin r = (ub == 0) ? 255 : ua / ub; m.dz = (ub == 0); m.lat = 8; neg_ok = 1'b0; end
      ALU_MOD: begin r = (ub == 0) ? ua : ua % ub; m.dz = (ub == 0); m.lat = 8; neg_ok = 1'b0; end
      default: r = 0;
    endcase
    m.res = 8'(r & 255);
    m.flg = {ov, neg_ok & m.res[7], c, (m.res == 8'h00)};
    m.issue_cyc = 0;
    return m;
  endfunction

  // Scoreboard: each done pulse pops one expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        $display("txn %-5s result=0x%02h flag=%04b dz=%0d latency=%0d", e.name, result, flag, dz, cyc - e.issue_cyc);
        check({e.name, "_result"}, 32'(result), 32'(e.res));
        check({e.name, "_flag"}, 32'(flag), 32'(e.flg));
        check({e.name, "_dz"}, 32'(dz), 32'(e.dz));
        check({e.name, "_latency"}, 32'(cyc - e.issue_cyc), 32'(e.lat));
      end
    end
  end

  task automatic issue_exp(input alu_op_e o, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    op = o; register1 = a; register2 = b; start = 1'b1;
    e.issue_cyc = cyc + 1;
    q.push_back(e);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(posedge clk); #2;
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 32'(q.size()), 0);
      q.delete();
    end
  endtask

  vec_t vecs[23];

  initial begin
    exp_t e;
    int   snap;

    vecs[0]  = '{ALU_MUL,  8'd200, 8'd3,   8'h58, 4'b0010, 1'b0, 8};
    vecs[1]  = '{ALU_MULH, 8'd200, 8'd3,   8'h02, 4'b0000, 1'b0, 8};
    vecs[2]  = '{ALU_DIV,  8'd100, 8'd7,   8'd14, 4'b0000, 1'b0, 8};
    vecs[3]  = '{ALU_MOD,  8'd100, 8'd7,   8'd2,  4'b0000, 1'b0, 8};
    vecs[4]  = '{ALU_DIV,  8'h2A,  8'h00,  8'hFF, 4'b0000, 1'b1, 8};
    vecs[5]  = '{ALU_MOD,  8'h2A,  8'h00,  8'h2A, 4'b0000, 1'b1, 8};
    vecs[6]  = '{ALU_ADD,  8'hFF,  8'h01,  8'h00, 4'b0011, 1'b0, 1};
    vecs[7]  = '{ALU_SUB,  8'h05,  8'h03,  8'h02, 4'b0000, 1'b0, 1};
    vecs[8]  = '{ALU_SUB,  8'h03,  8'h05,  8'hFE, 4'b0110, 1'b0, 1};
    vecs[9]  = '{ALU_ADD,  8'h7F,  8'h01,  8'h80, 4'b1100, 1'b0, 1};
    vecs[10] = '{ALU_MUL,  8'h00,  8'h37,  8'h00, 4'b0001, 1'b0, 8};
    vecs[11] = '{ALU_MULH, 8'hFF,  8'hFF,  8'hFE, 4'b0000, 1'b0, 8};
    vecs[12] = '{ALU_MUL,  8'hFF,  8'hFF,  8'h01, 4'b0010, 1'b0, 8};
    vecs[13] = '{ALU_DIV,  8'hFF,  8'h01,  8'hFF, 4'b0000, 1'b0, 8};
    vecs[14] = '{ALU_MOD,  8'h07,  8'h64,  8'h07, 4'b0000, 1'b0, 8};
    vecs[15] = '{ALU_DIV,  8'h00,  8'h00,  8'hFF, 4'b0000, 1'b1, 8};
    vecs[16] = '{ALU_MOD,  8'h00,  8'h00,  8'h00, 4'b0001, 1'b1, 8};
    vecs[17] = '{ALU_AND,  8'hF0,  8'h3C,  8'h30, 4'b0000, 1'b0, 1};
    vecs[18] = '{ALU_XOR,  8'hAA,  8'hAA,  8'h00, 4'b0001, 1'b0, 1};
    vecs[19] = '{ALU_SHL,  8'h81,  8'h00,  8'h02, 4'b0010, 1'b0, 1};
    vecs[20] = '{ALU_SHR,  8'h81,  8'h00,  8'h40, 4'b0010, 1'b0, 1};
    vecs[21] = '{ALU_NOT,  8'h0F,  8'h00,  8'hF0, 4'b0100, 1'b0, 1};
    vecs[22] = '{ALU_OR,   8'h80,  8'h01,  8'h81, 4'b0100, 1'b0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flag", 32'(flag), 0);
    check("rst_dz", 32'(dz), 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Table vectors, issued back-to-back in the DONE cycle
    for (int i = 0; i < 23; i++) begin
      e.name = vecs[i].op.name();
      e.res = vecs[i].res; e.flg = vecs[i].flg; e.dz = vecs[i].dz; e.lat = vecs[i].lat;
      issue_exp(vecs[i].op, vecs[i].a, vecs[i].b, e);
      wait_idle(20);
    end

    // Random operations against the reference model
    for (int i = 0; i < 16; i++) begin
      alu_op_e    ro;
      logic [7:0] ra, rb;
      ro = alu_op_e'($urandom_range(0, 11));
      ra = 8'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      issue_exp(ro, ra, rb, model(ro, ra, rb));
      wait_idle(20);
    end

    // start held high: ignored in RUN, accepted in DONE
    op = ALU_ADD; register1 = 8'hFF; register2 = 8'h01; start = 1'b1;
    e = model(ALU_ADD, 8'hFF, 8'h01); e.issue_cyc = cyc + 1; q.push_back(e);
    @(posedge clk); #2;
    check("b2b_busy_run", 32'(busy), 1);
    @(posedge clk); #2;
    check("b2b_done_ready", 32'(ready & done), 1);
    op = ALU_SUB; register1 = 8'h05; register2 = 8'h03;
    e = model(ALU_SUB, 8'h05, 8'h03); e.issue_cyc = cyc + 1; q.push_back(e);
    @(posedge clk); #2;
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 1);
    wait_idle(20);

    // Operand changes and a start pulse during RUN are ignored
    snap = done_cnt;
    issue_exp(ALU_MUL, 8'd200, 8'd3, model(ALU_MUL, 8'd200, 8'd3));
    repeat (3) @(posedge clk);
    #2;
    op = ALU_ADD; register1 = 8'h11; register2 = 8'h22; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle(20);
    repeat (4) @(posedge clk);
    #2;
    check("run_start_single_done", 32'(done_cnt - snap), 1);

    // Reset at iteration 4 of a DIV aborts without done
    issue_exp(ALU_DIV, 8'd100, 8'd7, model(ALU_DIV, 8'd100, 8'd7));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    q.delete();
    snap = done_cnt;
    check("abort_ready", 32'(ready), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_result", 32'(result), 0);
    check("abort_flag", 32'(flag), 0);
    repeat (16) @(posedge clk);
    #2;
    check("abort_no_done", 32'(done_cnt - snap), 0);
    e.name = "MUL"; e.res = 8'h8F; e.flg = 4'b0000; e.dz = 1'b0; e.lat = 8;
    issue_exp(ALU_MUL, 8'd13, 8'd11, e);
    wait_idle(20);
    @(posedge clk); #2;

    // Reset and start in the same cycle: start dropped
    snap = done_cnt;
    rst = 1'b1; start = 1'b1; op = ALU_MUL; register1 = 8'd9; register2 = 8'd9;
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 0);
    check("rst_start_ready", 32'(ready), 1);
    repeat (12) @(posedge clk);
    #2;
    check("rst_start_no_done", 32'(done_cnt - snap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle `alu`. It wraps the existing combinational `alu` for all current `alu_op_e` operations and adds unsigned iterative multiply (low and high half), divide and modulo behind a start/done handshake. It sits between the register file and the control FSM. The control FSM issues an op, stalls on `busy`, and writes back `result` when `done` is asserted.

## Interface
Parameters:
- `DATA_BUS_WIDTH`, default 8: operand and result width W (≥ 2).

Ports:
- `clk`: input, 1. Single clock. All state updates on the rising edge.
- `rst`: input, 1. Reset is synchronous and active-high.
- `start`: input, 1. Request; sampled only when `ready`=1.
- `op`: input, `alu_op_e`. Operation; captured with `start`.
- `register1`: input, W. Operand A / dividend / multiplicand; captured with `start`.
- `register2`: input, W. Operand B / divisor / multiplier; captured with `start`.
- `ready`: output, 1. Block accepts `start` this cycle.
- `busy`: output, 1. An operation is in flight. Equals `~ready`.
- `done`: output, 1. One-cycle pulse; `result`/`flag`/`dz` are valid.
- `result`: output, W. Held from `done` until the next accepted `start`.
- `flag`: output, `alu_flag_t`. Held with `result`.
- `dz`: output, 1. Divide-by-zero on the last DIV/MOD. Held with `result`.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE and DONE: `ready`=1.
  - RUN: `ready`=0.
- Accepted start (`start & ready`) at edge E0:
  - Latch `op` and both operands into internal registers.
  - Later input changes are ignored until the next accept.
- Existing ops (all legacy `alu_op_e` values): the `alu` sub-module evaluates the latched operands. At E1 `result`/`flag` are registered and the state goes to DONE. Latency L=1.
- Multiply op `ALU_MUL` (low W bits) and `ALU_MULH` (high W bits), unsigned:
  - Shift-add with a 2W-bit accumulator, one multiplier bit per cycle.
  - W iterations at E1..EW, so L=W.
- Divide op `ALU_DIV` (quotient) and `ALU_MOD` (remainder), unsigned:
  - Restoring division, one quotient bit per cycle, W iterations, so L=W.
- Divisor = 0:
  - Still runs for W cycles (fixed latency).
  - Quotient = all ones; remainder = dividend; `dz`=1.
  - `dz`=0 for every other op.
- Flags for new ops:
  - zero = (result==0).
  - carry: for MUL, 1 iff the high half is nonzero. For MULH, DIV and MOD it is 0.
  - Other `alu_flag_t` fields are 0.
- DONE lasts exactly one cycle (`done`=1), then the state returns to IDLE.
- A `start` in the DONE cycle is accepted (back-to-back issue).
- `start` while RUN is ignored; no queueing.
- Iteration counter: ⌈log2(W+1)⌉ bits. It loads W on accept and decrements each RUN cycle; leave RUN when it reaches 1.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, `flag`=0, `dz`=0, internal registers 0.
- Reset mid-RUN: aborts at that edge with no `done`, and all outputs return to their reset values.
- Reset and `start` in the same cycle: reset wins and the start is dropped.
- `done` is high in the cycle following edge E_L (L=1 for legacy ops, L=W for MUL/MULH/DIV/MOD).
- `busy` is high from the cycle after E0 through the cycle containing E_L.
- Throughput:
  - One legacy op per 2 cycles with back-to-back start in DONE; DONE and the next accept overlap.
  - One multi-cycle op per W+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `controlpack`:
  - Extend `alu_op_e` with `ALU_MUL`, `ALU_MULH`, `ALU_DIV` and `ALU_MOD`; the existing encodings are unchanged.
  - Add `alu_mc_state_e` (IDLE, RUN, DONE).
- `alu` is instantiated unchanged as the single sub-module, with `DATA_BUS_WIDTH` passed through. It receives the latched operands. Its outputs are ignored for the new ops.
- Multiply and divide share one 2W-bit shift register and one W+1-bit adder/subtractor.

## Test plan
- W=8, MUL 200×3:
  - `done` exactly 8 cycles after accept, `result`=0x58, carry=1, zero=0.
  - MULH with the same operands gives `result`=0x02.
- DIV 100/7 gives `result`=14 and MOD gives `result`=2, each with L=8 and `dz`=0.
- DIV 0x2A/0 gives `result`=0xFF and `dz`=1; MOD 0x2A/0 gives `result`=0x2A and `dz`=1. Both have L=8.
- Legacy op (e.g. add 0xFF+0x01):
  - `done` 1 cycle after accept, `result` and flags identical to standalone `alu`.
  - `start` held high in the DONE cycle is accepted.
- Operands changed and `start` pulsed during RUN: result unaffected, second start ignored, `done` pulses once.
- `rst` asserted at iteration 4 of a DIV: next cycle `ready`=1, `result`=0, and no `done` is ever emitted. A fresh MUL 13×11 then returns 0x8F.
